// File: rtl/fpu_wb_buffer.sv
// FPU result write-back buffer.
// Holds FPU results that cannot be written to the register file because the
// integer pipeline owns the write port, and drains them in arrival order.
// When the buffer is empty and the port is free, a result goes straight to the
// write port one cycle later. Also reports the number of buffered entries, a
// mask of destination registers with a pending write, an issue stall, and a
// sticky overflow flag.
module fpu_wb_buffer #(
  parameter int DEPTH = 8,
  parameter int SKID  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fpu_valid,
  input  logic [4:0]                 fpu_dest,
  input  logic [31:0]                fpu_result,
  input  logic                       wb_port_busy,
  output logic                       wb_valid,
  output logic [4:0]                 wb_dest,
  output logic [31:0]                wb_result,
  output logic                       fpu_stall,
  output logic [31:0]                pending_mask,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_LEVEL = (AW+1)'(DEPTH - SKID);

  logic [4:0]    dest_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic accept;
  logic drain;
  logic pop;
  logic bypass;
  logic push_req;
  logic push;
  logic drop;

  // Decide what happens this cycle: pop to the write port, bypass, push, or drop.
  always_comb begin
    accept   = fpu_valid && (fpu_dest != 5'd0);
    drain    = !wb_port_busy;
    pop      = drain && (count != '0);
    bypass   = drain && (count == '0) && accept;
    push_req = accept && !bypass;
    // A pop in the same cycle frees the slot the push needs, so a full
    // buffer still accepts the result when it is draining.
    push     = push_req && ((count != FULL_LEVEL) || pop);
    drop     = push_req && (count == FULL_LEVEL) && !pop;
  end

  // Entry storage.
  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      dest_mem[wr_ptr] <= fpu_dest;
      data_mem[wr_ptr] <= fpu_result;
    end
  end

  // Pointers, occupancy, overflow flag and the registered write-port outputs.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update together from the values sampled at the clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_dest   <= 5'd0;
      wb_result <= 32'd0;
    end else begin
      wb_valid <= pop || bypass;
      if (pop) begin
        wb_dest   <= dest_mem[rd_ptr];
        wb_result <= data_mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (bypass) begin
        wb_dest   <= fpu_dest;
        wb_result <= fpu_result;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Pending-register mask: OR of one-hot destinations over the occupied slots.
  // NOTE: the mask gets its default before the loop, so no latch is inferred.
  always_comb begin
    pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      // A slot is occupied when its distance past the read pointer is below count.
      if ({1'b0, AW'(i) - rd_ptr} < count) begin
        pending_mask[dest_mem[i]] = 1'b1;
      end
    end
    // Register 0 is never buffered, so bit 0 stays low even for stale slots.
    pending_mask[0] = 1'b0;
  end

  // Issue stall: leave SKID slots free for FPU operations already in flight.
  assign fpu_stall = (count >= STALL_LEVEL);

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Self-checking bench for fpu_wb_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fpu_wb_buffer;

  localparam int DEPTH = 8;
  localparam int SKID  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic          fpu_valid;
  logic [4:0]    fpu_dest;
  logic [31:0]   fpu_result;
  logic          wb_port_busy;
  logic          wb_valid;
  logic [4:0]    wb_dest;
  logic [31:0]   wb_result;
  logic          fpu_stall;
  logic [31:0]   pending_mask;
  logic [CW-1:0] count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  fpu_wb_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clock        (clock),
    .reset        (reset),
    .fpu_valid    (fpu_valid),
    .fpu_dest     (fpu_dest),
    .fpu_result   (fpu_result),
    .wb_port_busy (wb_port_busy),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .wb_result    (wb_result),
    .fpu_stall    (fpu_stall),
    .pending_mask (pending_mask),
    .count        (count),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a plain queue of pending results plus the expected
  // write-port registers and overflow flag.
  typedef struct {
    logic [4:0]  d;
    logic [31:0] r;
  } ent_t;

  ent_t        q[$];
  logic        m_wbv;
  logic [4:0]  m_wbd;
  logic [31:0] m_wbr;
  logic        m_ovf;

  task automatic model_clear();
    q.delete();
    m_wbv = 1'b0;
    m_wbd = 5'd0;
    m_wbr = 32'd0;
    m_ovf = 1'b0;
  endtask

  // One clock of the model: oldest result goes out if the port is free,
  // else a fresh result bypasses when nothing is waiting; otherwise the new
  // result joins the back of the queue, or is lost if there is no room.
  task automatic model_step(input logic v, input logic [4:0] d,
                            input logic [31:0] r, input logic b);
    logic acc;
    ent_t e;
    acc   = v && (d != 5'd0);
    m_wbv = 1'b0;
    if (!b && q.size() > 0) begin
      e     = q.pop_front();
      m_wbv = 1'b1;
      m_wbd = e.d;
      m_wbr = e.r;
    end else if (!b && acc) begin
      m_wbv = 1'b1;
      m_wbd = d;
      m_wbr = r;
      acc   = 1'b0;
    end
    if (acc) begin
      if (q.size() < DEPTH) begin
        e.d = d;
        e.r = r;
        q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = 32'd0;
    foreach (q[i]) m[q[i].d] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wb_valid"},  32'(wb_valid),  32'(m_wbv));
    check({tag, ".wb_dest"},   32'(wb_dest),   32'(m_wbd));
    check({tag, ".wb_result"}, wb_result,      m_wbr);
    check({tag, ".count"},     32'(count),     32'(q.size()));
    check({tag, ".stall"},     32'(fpu_stall), 32'(q.size() >= DEPTH - SKID));
    check({tag, ".mask"},      pending_mask,   model_mask());
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // compare every output just after the rising edge.
  task automatic cycle(input string tag, input logic v, input logic [4:0] d,
                       input logic [31:0] r, input logic b);
    @(negedge clock);
    fpu_valid    = v;
    fpu_dest     = d;
    fpu_result   = r;
    wb_port_busy = b;
    model_step(v, d, r, b);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset        = 1'b1;
    fpu_valid    = 1'b0;
    fpu_dest     = 5'd0;
    fpu_result   = 32'd0;
    wb_port_busy = 1'b0;
    model_clear();
    #1;
    check_all({tag, ".async"});
    @(posedge clock);
    #1;
    check_all(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    fpu_valid    = 1'b0;
    fpu_dest     = 5'd0;
    fpu_result   = 32'd0;
    wb_port_busy = 1'b0;
    model_clear();

    // Reset state.
    do_reset("reset");
    check("reset.wb_valid_const", 32'(wb_valid), 32'd0);
    check("reset.count_const",    32'(count),    32'd0);

    // Bypass with an empty buffer and a free port.
    cycle("byp", 1'b1, 5'd5, 32'h3F80_0000, 1'b0);
    check("byp.dest_const",   32'(wb_dest), 32'd5);
    check("byp.result_const", wb_result,    32'h3F80_0000);
    check("byp.count_const",  32'(count),   32'd0);
    cycle("byp_idle", 1'b0, 5'd0, 32'd0, 1'b0);

    // Buffering while busy, then in-order drain.
    cycle("buf1", 1'b1, 5'd1, 32'h1111_1111, 1'b1);
    cycle("buf2", 1'b1, 5'd2, 32'h2222_2222, 1'b1);
    cycle("buf3", 1'b1, 5'd3, 32'h3333_3333, 1'b1);
    check("buf.mask_const", pending_mask, 32'h0000_000E);
    check("buf.stall_const", 32'(fpu_stall), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cycle("drain", 1'b0, 5'd0, 32'd0, 1'b0);
      check("drain.dest_const", 32'(wb_dest), 32'(i));
    end
    check("drain.mask_const", pending_mask, 32'd0);

    // Fill to the stall level, to full, then one push too many.
    for (int i = 0; i < 9; i++) begin
      cycle("fill", 1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b1);
      if (i == 3) check("fill.stall_const", 32'(fpu_stall), 32'd1);
      if (i == 7) check("fill.count_full", 32'(count), 32'd8);
    end
    check("full.overflow_const", 32'(overflow), 32'd1);
    check("full.count_const",    32'(count),    32'd8);
    for (int i = 0; i < 8; i++) begin
      cycle("full_drain", 1'b0, 5'd0, 32'd0, 1'b0);
      check("full_drain.dest_const", 32'(wb_dest), 32'(10 + i));
    end
    cycle("full_after", 1'b0, 5'd0, 32'd0, 1'b0);
    check("full_after.valid_const", 32'(wb_valid), 32'd0);

    // Push and pop in the same cycle.
    cycle("pp_a", 1'b1, 5'd8, 32'h0000_0008, 1'b1);
    cycle("pp_b", 1'b1, 5'd9, 32'h0000_0009, 1'b1);
    cycle("pp_c", 1'b1, 5'd7, 32'h0000_0007, 1'b0);
    check("pp.count_const", 32'(count), 32'd2);
    cycle("pp_d", 1'b0, 5'd0, 32'd0, 1'b0);
    cycle("pp_e", 1'b0, 5'd0, 32'd0, 1'b0);
    check("pp.third_dest", 32'(wb_dest), 32'd7);

    // Register 0 is ignored; duplicate destinations hold their mask bit.
    cycle("r0", 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1);
    cycle("dup1", 1'b1, 5'd4, 32'h0000_0041, 1'b1);
    cycle("dup2", 1'b1, 5'd4, 32'h0000_0042, 1'b1);
    cycle("dup_pop1", 1'b0, 5'd0, 32'd0, 1'b0);
    check("dup.bit4_held", 32'(pending_mask[4]), 32'd1);
    cycle("dup_pop2", 1'b0, 5'd0, 32'd0, 1'b0);
    check("dup.bit4_clear", 32'(pending_mask[4]), 32'd0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 6; i++) cycle("pre_rst", 1'b1, 5'(20 + i), 32'(i), 1'b1);
    cycle("mid_drain", 1'b0, 5'd0, 32'd0, 1'b0);
    check("mid_drain.count", 32'(count), 32'd5);
    do_reset("mid_rst");
    check("mid_rst.overflow_const", 32'(overflow), 32'd0);
    cycle("post_rst", 1'b0, 5'd0, 32'd0, 1'b0);
    check("post_rst.valid_const", 32'(wb_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic       b;
      logic [4:0] d;
      v = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 9) < (i < 200 ? 6 : 3));
      d = 5'($urandom_range(0, 31));
      cycle("rand", v, d, $urandom, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_wb_buffer.md
FPU_WB_BUFFER -- requirements
Module: fpu_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of buffered result entries (power of two, 4..16).
REQ-002 Parameter SKID, default 4, entries reserved for FPU ops already in flight when stall asserts (1..DEPTH-1).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fpu_valid  input  1  FPU result present this cycle.
REQ-006 fpu_dest  input  5  destination register of FPU result.
REQ-007 fpu_result  input  32  FPU result data.
REQ-008 wb_port_busy  input  1  integer pipeline owns the register-file write port this cycle.
REQ-009 wb_valid  output  1  registered write-enable to register file.
REQ-010 wb_dest  output  5  registered write register index.
REQ-011 wb_result  output  32  registered write data.
REQ-012 fpu_stall  output  1  issue stage shall not start new FPU ops while high.
REQ-013 pending_mask  output  32  bit d high while any buffered entry targets register d.
REQ-014 count  output  $clog2(DEPTH)+1  current number of buffered entries.
REQ-015 overflow  output  1  sticky: a result was lost to a full buffer.

Function
REQ-016 Storage: circular FIFO of DEPTH entries {dest[4:0], data[31:0]}, read and write pointers wrap modulo DEPTH.
REQ-017 Results with fpu_dest==0 shall be discarded: not pushed, not bypassed, not written back.
REQ-018 Drain condition: wb_port_busy==0.
REQ-019 Per cycle, when drain and count>0: head entry loads wb_* at next edge with wb_valid=1; head popped.
REQ-020 When drain, count==0, fpu_valid, fpu_dest!=0: incoming result bypasses FIFO into wb_* at next edge (latency 1 cycle); no push.
REQ-021 Any other accepted result (fpu_valid, fpu_dest!=0, not bypassed) shall be pushed at tail.
REQ-022 Simultaneous push and pop: both occur, count unchanged, order preserved (pushed entry behind all existing entries).
REQ-023 When no entry is written back in a cycle, wb_valid shall be 0 at next edge; wb_dest/wb_result hold previous values.
REQ-024 wb_valid shall never be 1 in the cycle after wb_port_busy==1.
REQ-025 Results shall be written back strictly in arrival order.
REQ-026 Full: push attempt with count==DEPTH and no simultaneous pop drops the incoming result, count stays DEPTH, overflow sets and holds until reset.
REQ-027 Full with simultaneous pop: push accepted, no overflow.
REQ-028 fpu_stall = (count >= DEPTH-SKID), combinational from registered count.
REQ-029 pending_mask combinational OR over valid entries of one-hot(dest); bit 0 always 0; entries with equal dest keep bit set until last one pops.
REQ-030 count shall equal pushes minus pops since reset, range 0..DEPTH.
REQ-031 Block has no other state; no state machine beyond FIFO occupancy (EMPTY: count==0, bypass allowed; PARTIAL; FULL: count==DEPTH).

Reset
REQ-032 While reset high: wb_valid=0, wb_dest=0, wb_result=0, count=0, pointers=0, overflow=0, fpu_stall=0, pending_mask=0.
REQ-033 Reset asserted mid-operation discards all buffered entries and any in-progress write; no wb_valid pulse on first edge after release.
REQ-034 First accepted result after reset release behaves per REQ-019..021 with no extra latency.

Verification
REQ-035 Bypass: count=0, busy=0, fpu_valid dest=5 data=0x3F800000 -> next cycle wb_valid=1 wb_dest=5 wb_result=0x3F800000, count stays 0.
REQ-036 Buffering/order: busy=1 for 3 cycles, results dest 1,2,3 -> count=3, pending_mask=0x0000000E, fpu_stall=0; busy=0 -> wb_dest 1,2,3 on three consecutive cycles, then pending_mask=0.
REQ-037 Stall/full: DEPTH=8 SKID=4, busy=1, push 4 -> fpu_stall=1; push 4 more -> count=8; 9th push -> dropped, overflow=1, count=8; busy=0 drains exactly 8 entries in order.
REQ-038 Simultaneous push/pop: count=2, busy=0, fpu_valid dest=7 -> count=2, entry dest 7 written back third.
REQ-039 r0 and duplicates: push dest 0 -> ignored; push dest 4 twice while busy -> pending_mask bit 4 stays 1 after first pop, clears after second.
REQ-040 Reset mid-drain: count=5, assert reset one cycle -> all outputs 0, no wb_valid after release, overflow=0.
